// File: rtl/mem_addr_seq_pkg.sv
// Shared types and defaults for the mem_addr_seq row x column address sequencer.
package mem_addr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int ADDR_BW_DEF = 12;
  localparam int STALL_BW    = 16;

endpackage

// File: rtl/mem_addr_seq_idx.sv
// Wrapping index register with clear, increment and a registered "at last value" flag.
module mem_addr_seq_idx
  import mem_addr_seq_pkg::*;
#(
  parameter int BW    = 6,
  parameter int LIMIT = 50
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [BW-1:0] idx,
  output logic          last
);

  localparam logic [BW-1:0] MAX_IDX  = BW'(LIMIT - 1);
  localparam logic          CLR_LAST = (LIMIT == 1);

  logic [BW-1:0] idx_q, idx_d;
  logic          last_q, last_d;

  // The last flag is computed from the next index so it is ready with the beat it describes.
  always_comb begin
    idx_d  = idx_q;
    last_d = last_q;
    if (clr) begin
      idx_d  = '0;
      last_d = CLR_LAST;
    end else if (inc) begin
      idx_d  = last_q ? '0 : idx_q + BW'(1);
      last_d = (idx_d == MAX_IDX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      last_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      last_q <= last_d;
    end
  end

  assign idx  = idx_q;
  assign last = last_q;

endmodule

// File: rtl/mem_addr_seq.sv
// Row x column BRAM address sequencer with valid/ready output and done pulse.
// Optional stall cycle counter enabled by defining MEM_ADDR_SEQ_STALL_CNT_EN.
module mem_addr_seq
  import mem_addr_seq_pkg::*;
#(
  parameter int ROW_BW  = 6,
  parameter int COL_BW  = 6,
  parameter int ADDR_BW = ADDR_BW_DEF,
  parameter int N_ROWS  = 50,
  parameter int N_COLS  = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_BW-1:0] base_addr,
  input  logic               rdy,
  output logic               vld,
  output logic [ADDR_BW-1:0] addr,
  output logic [ROW_BW-1:0]  row_idx,
  output logic [COL_BW-1:0]  col_idx,
  output logic               last_col,
  output logic               last_row,
  output logic               busy,
`ifdef MEM_ADDR_SEQ_STALL_CNT_EN
  output logic [STALL_BW-1:0] stall_cnt,
`endif
  output logic               done
);

  state_e             state_q, state_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ADDR_BW-1:0] addr_q, addr_d;

  logic col_last, row_last;
  logic accept, final_beat, start_acc;

  assign accept     = vld_q & rdy;
  assign final_beat = accept & col_last & row_last;
  assign start_acc  = (state_q == IDLE) & start;

  // Counters restart on a new pass and again after the final beat, so they sit at zero between passes.
  mem_addr_seq_idx #(.BW(COL_BW), .LIMIT(N_COLS)) u_col (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc | final_beat),
    .inc   (accept),
    .idx   (col_idx),
    .last  (col_last)
  );

  mem_addr_seq_idx #(.BW(ROW_BW), .LIMIT(N_ROWS)) u_row (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc | final_beat),
    .inc   (accept & col_last),
    .idx   (row_idx),
    .last  (row_last)
  );

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
          addr_d  = base_addr;
        end
      end
      RUN: begin
        if (accept) begin
          addr_d = addr_q + ADDR_BW'(1);
          if (col_last && row_last) begin
            state_d = DONE;
            vld_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
    end
  end

`ifdef MEM_ADDR_SEQ_STALL_CNT_EN
  logic [STALL_BW-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (vld_q && !rdy && (stall_q != {STALL_BW{1'b1}})) begin
      stall_d = stall_q + STALL_BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

  // Flags are only meaningful alongside a presented beat.
  assign vld      = vld_q;
  assign addr     = addr_q;
  assign last_col = vld_q & col_last;
  assign last_row = vld_q & row_last;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mem_addr_seq.sv
// Bench for mem_addr_seq: three configurations (2x3, 1x4, 1x1) checked against a pass-level model.
module tb_mem_addr_seq;

  localparam int NI = 3;

  int nr[NI] = '{2, 1, 1};
  int nc[NI] = '{3, 4, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i [NI];
  logic [11:0] base_i  [NI];
  logic        rdy_i   [NI];
  logic        vld_o   [NI];
  logic [11:0] addr_o  [NI];
  logic [5:0]  row_o   [NI];
  logic [5:0]  col_o   [NI];
  logic        lc_o    [NI];
  logic        lr_o    [NI];
  logic        busy_o  [NI];
  logic        done_o  [NI];
`ifdef MEM_ADDR_SEQ_STALL_CNT_EN
  logic [15:0] stall_o [NI];
`endif

  int compared   = 0;
  int mismatched = 0;

  int m_phase [NI];
  int m_beat  [NI];
  int m_base  [NI];
  int m_stall [NI];

  always #5 clk = ~clk;

  mem_addr_seq #(.ROW_BW(6), .COL_BW(6), .ADDR_BW(12), .N_ROWS(2), .N_COLS(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .base_addr(base_i[0]), .rdy(rdy_i[0]),
    .vld(vld_o[0]), .addr(addr_o[0]), .row_idx(row_o[0]), .col_idx(col_o[0]),
    .last_col(lc_o[0]), .last_row(lr_o[0]), .busy(busy_o[0]),
`ifdef MEM_ADDR_SEQ_STALL_CNT_EN
    .stall_cnt(stall_o[0]),
`endif
    .done(done_o[0])
  );

  mem_addr_seq #(.ROW_BW(6), .COL_BW(6), .ADDR_BW(12), .N_ROWS(1), .N_COLS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .base_addr(base_i[1]), .rdy(rdy_i[1]),
    .vld(vld_o[1]), .addr(addr_o[1]), .row_idx(row_o[1]), .col_idx(col_o[1]),
    .last_col(lc_o[1]), .last_row(lr_o[1]), .busy(busy_o[1]),
`ifdef MEM_ADDR_SEQ_STALL_CNT_EN
    .stall_cnt(stall_o[1]),
`endif
    .done(done_o[1])
  );

  mem_addr_seq #(.ROW_BW(6), .COL_BW(6), .ADDR_BW(12), .N_ROWS(1), .N_COLS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_i[2]), .base_addr(base_i[2]), .rdy(rdy_i[2]),
    .vld(vld_o[2]), .addr(addr_o[2]), .row_idx(row_o[2]), .col_idx(col_o[2]),
    .last_col(lc_o[2]), .last_row(lr_o[2]), .busy(busy_o[2]),
`ifdef MEM_ADDR_SEQ_STALL_CNT_EN
    .stall_cnt(stall_o[2]),
`endif
    .done(done_o[2])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pass-level model: phase 0 idle, 1 presenting beat m_beat, 2 done cycle.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_phase[i] <= 0;
        m_beat[i]  <= 0;
        m_stall[i] <= 0;
      end else begin
        case (m_phase[i])
          0: if (start_i[i]) begin
               m_phase[i] <= 1;
               m_beat[i]  <= 0;
               m_base[i]  <= int'(base_i[i]);
               m_stall[i] <= 0;
             end
          1: if (rdy_i[i]) begin
               if (m_beat[i] == nr[i] * nc[i] - 1) m_phase[i] <= 2;
               else m_beat[i] <= m_beat[i] + 1;
             end else if (m_stall[i] < 65535) begin
               m_stall[i] <= m_stall[i] + 1;
             end
          default: m_phase[i] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int r, c, a;
      r = m_beat[i] / nc[i];
      c = m_beat[i] % nc[i];
      a = (m_base[i] + r * nc[i] + c) % 4096;
      checkOutput($sformatf("i%0d vld", i), 32'(vld_o[i]), 32'(m_phase[i] == 1));
      checkOutput($sformatf("i%0d busy", i), 32'(busy_o[i]), 32'(m_phase[i] != 0));
      checkOutput($sformatf("i%0d done", i), 32'(done_o[i]), 32'(m_phase[i] == 2));
      if (!rst_n) begin
        checkOutput($sformatf("i%0d rst addr", i), 32'(addr_o[i]), 32'd0);
        checkOutput($sformatf("i%0d rst row", i), 32'(row_o[i]), 32'd0);
        checkOutput($sformatf("i%0d rst col", i), 32'(col_o[i]), 32'd0);
      end
      if (m_phase[i] == 1) begin
        checkOutput($sformatf("i%0d addr", i), 32'(addr_o[i]), 32'(a));
        checkOutput($sformatf("i%0d row", i), 32'(row_o[i]), 32'(r));
        checkOutput($sformatf("i%0d col", i), 32'(col_o[i]), 32'(c));
        checkOutput($sformatf("i%0d last_col", i), 32'(lc_o[i]), 32'(c == nc[i] - 1));
        checkOutput($sformatf("i%0d last_row", i), 32'(lr_o[i]), 32'(r == nr[i] - 1));
      end
`ifdef MEM_ADDR_SEQ_STALL_CNT_EN
      checkOutput($sformatf("i%0d stall_cnt", i), 32'(stall_o[i]), 32'(m_stall[i]));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; on return the first beat is on the outputs.
  task automatic applyStimulus(input int i, input logic [11:0] b);
    step();
    start_i[i] = 1'b1;
    base_i[i]  = b;
    step();
    start_i[i] = 1'b0;
  endtask

  task automatic waitPhase(input int i, input int ph, input string tag);
    bit hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      if (m_phase[i] == ph) hit = 1'b1;
      else step();
    end
    compared++;
    if (!hit) begin
      mismatched++;
      $display("[TB] FAIL %s timeout: phase %0d, expected %0d", tag, m_phase[i], ph);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_i[i] = 1'b0;
      base_i[i]  = '0;
      rdy_i[i]   = 1'b1;
    end
    #2;
    checkOutput("reset vld", 32'(vld_o[0]), 32'd0);
    checkOutput("reset addr", 32'(addr_o[0]), 32'd0);
    checkOutput("reset done", 32'(done_o[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] case 1: 2x3 full rate");
    applyStimulus(0, 12'h010);
    checkOutput("t1 b1 vld", 32'(vld_o[0]), 32'd1);
    checkOutput("t1 b1 addr", 32'(addr_o[0]), 32'h010);
    step(); step();
    checkOutput("t1 b3 addr", 32'(addr_o[0]), 32'h012);
    checkOutput("t1 b3 last_col", 32'(lc_o[0]), 32'd1);
    checkOutput("t1 b3 last_row", 32'(lr_o[0]), 32'd0);
    step();
    checkOutput("t1 b4 addr", 32'(addr_o[0]), 32'h013);
    checkOutput("t1 b4 last_row", 32'(lr_o[0]), 32'd1);
    step(); step(); step();
    checkOutput("t1 done", 32'(done_o[0]), 32'd1);
    waitPhase(0, 0, "t1 idle");

    $display("[TB] case 2: 2x3 with rdy 1,0,0 pattern");
    applyStimulus(0, 12'h010);
    for (int k = 0; k < 60 && m_phase[0] != 0; k++) begin
      rdy_i[0] = (k % 3 == 0);
      step();
    end
    rdy_i[0] = 1'b1;
    waitPhase(0, 0, "t2 idle");

    $display("[TB] case 3: address wrap");
    applyStimulus(1, 12'hFFE);
    checkOutput("t3 b1 addr", 32'(addr_o[1]), 32'hFFE);
    step(); step();
    checkOutput("t3 b3 addr", 32'(addr_o[1]), 32'h000);
    step();
    checkOutput("t3 b4 addr", 32'(addr_o[1]), 32'h001);
    checkOutput("t3 b4 last_col", 32'(lc_o[1]), 32'd1);
    step();
    checkOutput("t3 done", 32'(done_o[1]), 32'd1);
    waitPhase(1, 0, "t3 idle");

    $display("[TB] case 4: start during RUN and DONE");
    applyStimulus(0, 12'h100);
    step();
    start_i[0] = 1'b1;
    base_i[0]  = 12'h3AA;
    step();
    start_i[0] = 1'b0;
    waitPhase(0, 2, "t4 done");
    start_i[0] = 1'b1;
    base_i[0]  = 12'h222;
    step();
    base_i[0]  = 12'h055;
    step();
    start_i[0] = 1'b0;
    checkOutput("t4 new addr", 32'(addr_o[0]), 32'h055);
    waitPhase(0, 0, "t4 idle");

    $display("[TB] case 5: reset mid-pass");
    applyStimulus(0, 12'h020);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5 rst vld", 32'(vld_o[0]), 32'd0);
    checkOutput("t5 rst addr", 32'(addr_o[0]), 32'd0);
    checkOutput("t5 rst busy", 32'(busy_o[0]), 32'd0);
    step();
    rst_n = 1'b1;
    applyStimulus(0, 12'h020);
    checkOutput("t5 replay addr", 32'(addr_o[0]), 32'h020);
    checkOutput("t5 replay col", 32'(col_o[0]), 32'd0);
    waitPhase(0, 0, "t5 idle");

    $display("[TB] case 6: single beat");
    applyStimulus(2, 12'h123);
    checkOutput("t6 addr", 32'(addr_o[2]), 32'h123);
    checkOutput("t6 last_col", 32'(lc_o[2]), 32'd1);
    checkOutput("t6 last_row", 32'(lr_o[2]), 32'd1);
    step();
    checkOutput("t6 done", 32'(done_o[2]), 32'd1);
    checkOutput("t6 vld off", 32'(vld_o[2]), 32'd0);
    step();
    checkOutput("t6 done off", 32'(done_o[2]), 32'd0);
    checkOutput("t6 busy off", 32'(busy_o[2]), 32'd0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
